// File: rtl/mango_ps2_keyboard_if.sv
// Keyboard port bundle: raw PS/2 pins plus the Apple-1 style keycode/keystrobe pair.
interface mango_ps2_keyboard_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       keystrobe;
    logic [7:0] keycode;
    logic       parity_err;
    logic       overflow;

    modport master (
        output ps2_clk, ps2_data, keystrobe,
        input  keycode, parity_err, overflow
    );

    modport slave (
        input  ps2_clk, ps2_data, keystrobe,
        output keycode, parity_err, overflow
    );
endinterface

// File: rtl/mango_ps2_keyboard.sv
// PS/2 set-2 keyboard front end: frame receiver, modifier tracking, ASCII translation
// and a small character FIFO presented as {pending, ascii} on keycode.
module mango_ps2_keyboard #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 2000
) (
    input  logic                 clk,
    input  logic                 reset,
    mango_ps2_keyboard_if.slave  kbd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    logic r_ps2c_s1, r_ps2c_s2, r_ps2c_prev, r_ps2d_s1, r_ps2d_s2;
    logic r_ks_sync, r_ks_prev;
    logic w_fe;

    // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps2c_s1   <= 1'b1;
            r_ps2c_s2   <= 1'b1;
            r_ps2c_prev <= 1'b1;
            r_ps2d_s1   <= 1'b1;
            r_ps2d_s2   <= 1'b1;
            r_ks_sync   <= 1'b0;
            r_ks_prev   <= 1'b0;
        end else begin
            r_ps2c_s1   <= kbd.ps2_clk;
            r_ps2c_s2   <= r_ps2c_s1;
            r_ps2c_prev <= r_ps2c_s2;
            r_ps2d_s1   <= kbd.ps2_data;
            r_ps2d_s2   <= r_ps2d_s1;
            r_ks_sync   <= kbd.keystrobe;
            r_ks_prev   <= r_ks_sync;
        end
    end

    assign w_fe = r_ps2c_prev & ~r_ps2c_s2;

    state_t        r_state, w_state_next;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_frame;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;

    assign w_timeout = (r_to_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: defaulting the next state first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_fe && !r_ps2d_s2) w_state_next = SHIFT;
            SHIFT:   if (w_fe && r_bit_cnt == 4'd9) w_state_next = CHECK;
                     else if (!w_fe && w_timeout) w_state_next = IDLE;
            CHECK:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Frame assembles LSB first: [7:0] data, [8] parity, [9] stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_frame   <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == IDLE) r_bit_cnt <= '0;
            if (r_state == SHIFT && w_fe) begin
                r_frame   <= {r_ps2d_s2, r_frame[9:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_fe || r_state != SHIFT) r_to_cnt <= '0;
            else if (!w_timeout)          r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    logic       w_frame_ok;
    logic       r_byte_stb, r_parity_err;
    logic [7:0] r_byte;

    assign w_frame_ok = (^r_frame[8:0]) && r_frame[9];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_stb   <= 1'b0;
            r_parity_err <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_byte_stb   <= (r_state == CHECK) && w_frame_ok;
            r_parity_err <= (r_state == CHECK) && !w_frame_ok;
            if (r_state == CHECK) r_byte <= r_frame[7:0];
        end
    end

    logic       r_brk, r_ext, r_shift_l, r_shift_r, r_ctrl;
    logic [6:0] w_lo, w_hi, w_ascii;
    logic       w_letter, w_mapped, w_is_prefix, w_is_mod, w_push_req;

    // Letters only fill w_lo; their shifted form is derived below.
    always_comb begin
        w_lo = 7'h00;
        w_hi = 7'h00;
        case (r_byte)
            8'h1C: w_lo = 7'h61;  8'h32: w_lo = 7'h62;  8'h21: w_lo = 7'h63;
            8'h23: w_lo = 7'h64;  8'h24: w_lo = 7'h65;  8'h2B: w_lo = 7'h66;
            8'h34: w_lo = 7'h67;  8'h33: w_lo = 7'h68;  8'h43: w_lo = 7'h69;
            8'h3B: w_lo = 7'h6A;  8'h42: w_lo = 7'h6B;  8'h4B: w_lo = 7'h6C;
            8'h3A: w_lo = 7'h6D;  8'h31: w_lo = 7'h6E;  8'h44: w_lo = 7'h6F;
            8'h4D: w_lo = 7'h70;  8'h15: w_lo = 7'h71;  8'h2D: w_lo = 7'h72;
            8'h1B: w_lo = 7'h73;  8'h2C: w_lo = 7'h74;  8'h3C: w_lo = 7'h75;
            8'h2A: w_lo = 7'h76;  8'h1D: w_lo = 7'h77;  8'h22: w_lo = 7'h78;
            8'h35: w_lo = 7'h79;  8'h1A: w_lo = 7'h7A;
            8'h16: begin w_lo = 7'h31; w_hi = 7'h21; end
            8'h1E: begin w_lo = 7'h32; w_hi = 7'h40; end
            8'h26: begin w_lo = 7'h33; w_hi = 7'h23; end
            8'h25: begin w_lo = 7'h34; w_hi = 7'h24; end
            8'h2E: begin w_lo = 7'h35; w_hi = 7'h25; end
            8'h36: begin w_lo = 7'h36; w_hi = 7'h5E; end
            8'h3D: begin w_lo = 7'h37; w_hi = 7'h26; end
            8'h3E: begin w_lo = 7'h38; w_hi = 7'h2A; end
            8'h46: begin w_lo = 7'h39; w_hi = 7'h28; end
            8'h45: begin w_lo = 7'h30; w_hi = 7'h29; end
            8'h29: begin w_lo = 7'h20; w_hi = 7'h20; end
            8'h5A: begin w_lo = 7'h0D; w_hi = 7'h0D; end
            8'h66: begin w_lo = 7'h08; w_hi = 7'h08; end
            8'h76: begin w_lo = 7'h1B; w_hi = 7'h1B; end
            8'h4E: begin w_lo = 7'h2D; w_hi = 7'h5F; end
            8'h55: begin w_lo = 7'h3D; w_hi = 7'h2B; end
            8'h41: begin w_lo = 7'h2C; w_hi = 7'h3C; end
            8'h49: begin w_lo = 7'h2E; w_hi = 7'h3E; end
            8'h4A: begin w_lo = 7'h2F; w_hi = 7'h3F; end
            8'h4C: begin w_lo = 7'h3B; w_hi = 7'h3A; end
            8'h52: begin w_lo = 7'h27; w_hi = 7'h22; end
            default: ;
        endcase
        w_mapped = (w_lo != 7'h00);
        w_letter = (w_lo >= 7'h61) && (w_lo <= 7'h7A);
        if (w_letter) w_hi = w_lo & 7'h5F;
        if (r_ctrl && w_letter)          w_ascii = w_hi & 7'h1F;
        else if (r_shift_l || r_shift_r) w_ascii = w_hi;
        else                             w_ascii = w_lo;
    end

    assign w_is_prefix = (r_byte == 8'hF0) || (r_byte == 8'hE0);
    assign w_is_mod    = (r_byte == 8'h12) || (r_byte == 8'h59) || (r_byte == 8'h14);
    assign w_push_req  = r_byte_stb && !w_is_prefix && !w_is_mod && !r_brk && !r_ext && w_mapped;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_shift_l <= 1'b0;
            r_shift_r <= 1'b0;
            r_ctrl    <= 1'b0;
        end else if (r_parity_err) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (r_byte_stb) begin
            if (r_byte == 8'hF0)      r_brk <= 1'b1;
            else if (r_byte == 8'hE0) r_ext <= 1'b1;
            else begin
                if (r_byte == 8'h12) r_shift_l <= !r_brk;
                if (r_byte == 8'h59) r_shift_r <= !r_brk;
                if (r_byte == 8'h14) r_ctrl    <= !r_brk;
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end
    end

    logic [6:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_full, w_pop, w_push;

    assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop  = r_ks_sync && !r_ks_prev && (r_count != '0);
    assign w_push = w_push_req && (!w_full || w_pop);

    // NOTE: storage is left unreset; r_count gates every read so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_ascii;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
            if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign kbd.keycode    = (r_count != '0) ? {1'b1, r_mem[r_rd_ptr]} : 8'h00;
    assign kbd.parity_err = r_parity_err;
    assign kbd.overflow   = r_overflow;
endmodule
